// File: rtl/pcie_fc_pkg.sv
// Shared flow-control types, counter widths and the scale-field decode
// used by the TX credit gate and its per-slot credit trackers.
package pcie_fc_pkg;

  typedef enum logic [1:0] {FC_P = 2'd0, FC_NP = 2'd1, FC_CPL = 2'd2} fc_type_e;
  typedef enum logic [1:0] {UNINIT = 2'd0, INIT = 2'd1, ACTIVE = 2'd2} vc_state_e;

  localparam int HDR_W        = 12;
  localparam int DATA_W       = 16;
  localparam int NUM_FC_TYPES = 3;

  // Scale encodings 00 and 01 both mean x1.
  function automatic logic [2:0] fc_scale_shift(input logic [1:0] scale);
    case (scale)
      2'b10:   return 3'd2;
      2'b11:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/fc_credit_slot.sv
// Credit tracker for one (VC, FC type) pair: limit, consumed count, infinite
// flags, request sufficiency and UpdateFC sanity check.
module fc_credit_slot #(
  parameter int HDR_W  = 12,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              load_init,
  input  logic              load_upd,
  input  logic [HDR_W-1:0]  hdr_new,
  input  logic [DATA_W-1:0] data_new,
  input  logic              hdr_zero,
  input  logic              data_zero,
  input  logic              consume,
  input  logic [10:0]       data_cr,
  output logic              ready,
  output logic              err
);

  localparam logic [HDR_W-1:0]  HDR_HALF  = {1'b1, {(HDR_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] DATA_HALF = {1'b1, {(DATA_W-1){1'b0}}};

  logic [HDR_W-1:0]  hdr_limit_reg, hdr_cons_reg, hdr_room, hdr_gap;
  logic [DATA_W-1:0] data_limit_reg, data_cons_reg, data_need, data_room, data_gap;
  logic              hdr_inf_reg, data_inf_reg;

  assign data_need = DATA_W'(data_cr);

  // Modular distance: anything past half the counter range means "overdrawn".
  assign hdr_room  = hdr_limit_reg - (hdr_cons_reg + HDR_W'(1));
  assign data_room = data_limit_reg - (data_cons_reg + data_need);
  assign ready = (hdr_inf_reg || (hdr_room <= HDR_HALF)) &&
                 (data_inf_reg || (data_cr == 11'd0) || (data_room <= DATA_HALF));

  assign hdr_gap  = hdr_new - hdr_cons_reg;
  assign data_gap = data_new - data_cons_reg;
  assign err = load_upd && ((!hdr_inf_reg && (hdr_gap > HDR_HALF)) ||
                            (!data_inf_reg && (data_gap > DATA_HALF)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hdr_limit_reg  <= '0;
      data_limit_reg <= '0;
      hdr_cons_reg   <= '0;
      data_cons_reg  <= '0;
      hdr_inf_reg    <= 1'b0;
      data_inf_reg   <= 1'b0;
    end else if (clear) begin
      hdr_limit_reg  <= '0;
      data_limit_reg <= '0;
      hdr_cons_reg   <= '0;
      data_cons_reg  <= '0;
      hdr_inf_reg    <= 1'b0;
      data_inf_reg   <= 1'b0;
    end else begin
      if (load_init) begin
        hdr_limit_reg  <= hdr_new;
        data_limit_reg <= data_new;
        hdr_inf_reg    <= hdr_zero;
        data_inf_reg   <= data_zero;
      end else if (load_upd) begin
        if (!hdr_inf_reg)  hdr_limit_reg  <= hdr_new;
        if (!data_inf_reg) data_limit_reg <= data_new;
      end
      if (consume) begin
        hdr_cons_reg  <= hdr_cons_reg + HDR_W'(1);
        data_cons_reg <= data_cons_reg + data_need;
      end
    end
  end

endmodule

// File: rtl/tx_fc_credit_gate.sv
// TX flow-control credit gate: decodes FC DLLP fields, runs the per-VC init
// FSMs and gates the TLP arbiter request against the selected credit slot.
module tx_fc_credit_gate #(
  parameter int NUM_VC = 2,
  parameter int HDR_W  = pcie_fc_pkg::HDR_W,
  parameter int DATA_W = pcie_fc_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              link_up,
  input  logic              fc_valid,
  input  logic [2:0]        update_fc_type,
  input  logic              flow_control_type,
  input  logic [2:0]        vc,
  input  logic [1:0]        hdr_scale,
  input  logic [1:0]        data_scale,
  input  logic [7:0]        hdr_fc,
  input  logic [15:0]       data_fc,
  input  logic              tx_req_valid,
  input  logic [1:0]        tx_req_type,
  input  logic [2:0]        tx_req_vc,
  input  logic [10:0]       tx_req_data_cr,
  output logic              tx_req_ready,
  output logic [NUM_VC-1:0] vc_fc_active,
  output logic              fc_err
);
  import pcie_fc_pkg::*;

  localparam int NUM_SLOT = NUM_VC * NUM_FC_TYPES;

  logic                type_ok;
  logic [2:0]          type_bit;
  logic [HDR_W-1:0]    hdr_scaled;
  logic [DATA_W-1:0]   data_scaled;
  logic                hdr_zero, data_zero;
  logic                unused_data_hi;
  logic [NUM_SLOT-1:0] slot_ready, slot_err, slot_grant;

  assign type_ok        = (update_fc_type < 3'd3);
  assign type_bit       = 3'b001 << update_fc_type[1:0];
  assign hdr_scaled     = HDR_W'(hdr_fc) << fc_scale_shift(hdr_scale);
  assign data_scaled    = DATA_W'(data_fc[11:0]) << fc_scale_shift(data_scale);
  assign hdr_zero       = (hdr_fc == 8'd0);
  assign data_zero      = (data_fc[11:0] == 12'd0);
  assign unused_data_hi = ^data_fc[15:12];

  genvar gi, gj;
  generate
    for (gi = 0; gi < NUM_VC; gi++) begin : g_vc
      vc_state_e  state_reg;
      logic [2:0] seen_reg;
      logic [2:0] seen_next;
      logic       fc_hit, init_hit, upd_hit, vc_active;

      assign fc_hit    = fc_valid && link_up && type_ok && (vc == 3'(gi));
      assign init_hit  = fc_hit && flow_control_type && (state_reg != ACTIVE);
      assign upd_hit   = fc_hit && !flow_control_type && (state_reg == ACTIVE);
      assign seen_next = seen_reg | type_bit;
      assign vc_active = (state_reg == ACTIVE);
      assign vc_fc_active[gi] = vc_active;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_reg <= UNINIT;
          seen_reg  <= '0;
        end else if (!link_up) begin
          state_reg <= UNINIT;
          seen_reg  <= '0;
        end else if (init_hit) begin
          seen_reg  <= seen_next;
          state_reg <= (seen_next == 3'b111) ? ACTIVE : INIT;
        end
      end

      for (gj = 0; gj < NUM_FC_TYPES; gj++) begin : g_type
        localparam fc_type_e SLOT_TYPE = fc_type_e'(gj);
        localparam int       IDX       = gi * NUM_FC_TYPES + gj;
        logic type_hit, req_hit;

        assign type_hit = (update_fc_type == {1'b0, SLOT_TYPE});
        assign req_hit  = (tx_req_vc == 3'(gi)) && (tx_req_type == SLOT_TYPE);
        // link_up is folded in so a falling link kills ready and consume at once.
        assign slot_grant[IDX] = link_up && vc_active && req_hit && slot_ready[IDX];

        fc_credit_slot #(
          .HDR_W  (HDR_W),
          .DATA_W (DATA_W)
        ) u_slot (
          .clk       (clk),
          .rst_n     (rst_n),
          .clear     (!link_up),
          .load_init (init_hit && type_hit),
          .load_upd  (upd_hit && type_hit),
          .hdr_new   (hdr_scaled),
          .data_new  (data_scaled),
          .hdr_zero  (hdr_zero),
          .data_zero (data_zero),
          .consume   (tx_req_valid && slot_grant[IDX]),
          .data_cr   (tx_req_data_cr),
          .ready     (slot_ready[IDX]),
          .err       (slot_err[IDX])
        );
      end
    end
  endgenerate

  assign tx_req_ready = |slot_grant;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fc_err <= 1'b0;
    else        fc_err <= |slot_err;
  end

endmodule
